// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data memory: funct3 codes, FSM states, index helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Word-index width for a memory of 'depth' 32-bit words.
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for dmem_rv.
//  addr_lo    : byte offset within the word (addr[1:0])
//  funct3     : RV32 load/store width code
//  wdata      : raw store data
//  rword      : word read from the array
//  be_c       : byte enables for a store
//  wdata_c    : store data replicated onto its lanes
//  misalign_c : access crosses its natural alignment
//  illegal_c  : funct3 is not a defined load width
//  rdata_c    : load result, sign/zero extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [LANES-1:0]  be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic              misalign_c,
  output logic              illegal_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane extraction from the read word.
  always_comb begin
    byte_c = rword[7:0];
    case (addr_lo)
      2'd0: byte_c = rword[7:0];
      2'd1: byte_c = rword[15:8];
      2'd2: byte_c = rword[23:16];
      2'd3: byte_c = rword[31:24];
      default: byte_c = rword[7:0];
    endcase
    half_c = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Width decode: enables, replicated store data, extension, alignment.
  always_comb begin
    be_c       = '0;
    wdata_c    = wdata;
    misalign_c = 1'b0;
    illegal_c  = 1'b0;
    rdata_c    = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be_c    = LANES'(4'b0001 << addr_lo);
        wdata_c = {4{wdata[7:0]}};
        rdata_c = (funct3 == F3_B) ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
      end
      F3_H, F3_HU: begin
        misalign_c = addr_lo[0];
        be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = (funct3 == F3_H) ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
      end
      F3_W: begin
        misalign_c = (addr_lo != 2'd0);
        be_c       = 4'b1111;
        rdata_c    = rword;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_rv.sv
// RV32 data memory: one load/store per cycle, 1-cycle response, byte/half/word access,
// post-reset clear sweep.
//  clk, rst_n                 : clock, async active-low reset
//  req_valid/req_ready        : request handshake
//  req_we, req_funct3         : store flag and access width
//  req_addr, req_wdata        : byte address and store data
//  rsp_valid/rsp_rdata/rsp_err: registered response, one cycle after accept
//  init_done                  : clear sweep finished
module dmem_rv
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX = idx_w(DEPTH);

  state_t            state_q, state_d;
  logic [IDX-1:0]    cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept_c;
  logic [IDX-1:0]    req_idx_c;
  logic              oor_c;
  logic              st_illegal_c;
  logic              err_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [LANES-1:0]  al_be_c;
  logic [DATA_W-1:0] al_wdata_c;
  logic              al_misalign_c;
  logic              al_illegal_c;
  logic [DATA_W-1:0] al_rdata_c;

  logic              mem_we_c;
  logic [IDX-1:0]    mem_idx_c;
  logic [LANES-1:0]  mem_be_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign accept_c     = req_valid && req_ready_q;
  assign req_idx_c    = req_addr[IDX+1:2];
  assign oor_c        = |req_addr[ADDR_W-1:IDX+2];
  assign st_illegal_c = req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU));
  assign err_c        = al_misalign_c || al_illegal_c || oor_c || st_illegal_c;
  // A store on the previous edge is already in the array, so this read sees it.
  assign rd_word_c    = mem_q[req_idx_c];

  dmem_lane_align u_align (
    .addr_lo    (req_addr[1:0]),
    .funct3     (req_funct3),
    .wdata      (req_wdata),
    .rword      (rd_word_c),
    .be_c       (al_be_c),
    .wdata_c    (al_wdata_c),
    .misalign_c (al_misalign_c),
    .illegal_c  (al_illegal_c),
    .rdata_c    (al_rdata_c)
  );

  // Next state, sweep counter, array write port and response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    init_done_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = req_idx_c;
    mem_be_c    = al_be_c;
    mem_wdata_c = al_wdata_c;

    case (state_q)
      INIT: begin
        if (CLEAR_ON_RESET) begin
          mem_we_c    = 1'b1;
          mem_idx_c   = cnt_q;
          mem_be_c    = '1;
          mem_wdata_c = '0;
        end
        if (!CLEAR_ON_RESET || (cnt_q == IDX'(DEPTH - 1))) begin
          state_d     = READY;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX'(1);
        end
      end
      READY: begin
        req_ready_d = 1'b1;
        init_done_d = 1'b1;
        if (accept_c) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          mem_we_c    = req_we && !err_c;
          if (!req_we && !err_c) rsp_rdata_d = al_rdata_c;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled storage; deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (mem_we_c && mem_be_c[b]) mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_rv.sv
// Directed self-checking bench for dmem_rv with DEPTH=16, CLEAR_ON_RESET=1.
module tb_dmem_rv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_rv #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Single request; samples the response 1 time unit after the accepting edge.
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rd"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  // Release reset at a negedge and count rising edges until req_ready.
  task automatic release_and_count(input string tag);
    int cyc;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'd16);
    check({tag, "_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    // 1: reset values and sweep length
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    release_and_count("init");
    xfer("lw3c", 1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0);

    // 2: word store then sub-word loads
    xfer("sw8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("lbB", 1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0);
    xfer("lbuB", 1'b0, 3'b100, 32'hB, 32'h0, 32'h000000DE, 1'b0);
    xfer("lh8", 1'b0, 3'b001, 32'h8, 32'h0, 32'hFFFFBEEF, 1'b0);
    xfer("lhuA", 1'b0, 3'b101, 32'hA, 32'h0, 32'h0000DEAD, 1'b0);

    // 3: byte store into one lane
    xfer("sb9", 1'b1, 3'b000, 32'h9, 32'h12345677, 32'h0, 1'b0);
    xfer("lw8", 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD77EF, 1'b0);

    // 4: error cases leave memory untouched
    xfer("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1);
    xfer("sh3", 1'b1, 3'b001, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
    xfer("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    xfer("sbu", 1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
    xfer("lw8b", 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD77EF, 1'b0);

    // 5: back-to-back store then load of the same word
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = '0;
    check("b2b_sw_vld", 32'(rsp_valid), 32'd1);
    check("b2b_sw_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_lw_vld", 32'(rsp_valid), 32'd1);
    check("b2b_lw_rd", rsp_rdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("b2b_idle", 32'(rsp_valid), 32'd0);

    // 6a: reset with a response pending, then check the sweep cleared memory
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pend_vld", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0; #1;
    check("pend_drop", 32'(rsp_valid), 32'd0);
    check("pend_ready", 32'(req_ready), 32'd0);
    release_and_count("rst2");
    xfer("clr_lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 1'b0);
    xfer("clr_lw8", 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0);

    // 6b: reset mid-sweep restarts the count
    xfer("sw_c", 1'b1, 3'b010, 32'hC, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0; #1;
    check("mid_done", 32'(init_done), 32'd0);
    release_and_count("rst3");
    xfer("clr_lwC", 1'b0, 3'b010, 32'hC, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
